// File: rtl/eq_pkg.sv
// eq_pkg: audio-path types and constants shared by the equalizer blocks.
package eq_pkg;
    localparam int AUDIO_W    = 24;
    localparam int I2S_SLOT_W = 32;

    typedef logic signed [AUDIO_W-1:0] audio_sample_t;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/eq_i2s_clkgen.sv
// eq_i2s_clkgen: divides clk down to the I2S bit clock, tracks the bit position in
// the stereo frame and produces word select plus one-cycle fall/frame strobes.
module eq_i2s_clkgen
    import eq_pkg::*;
#(
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         fall_evt,
    output logic                         frame_evt,
    output logic [cnt_w(2*SLOT_W)-1:0]   bit_cnt
);
    localparam int BIT_W = cnt_w(2*SLOT_W);
    localparam int DIV_W = cnt_w(BCLK_DIV);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2*SLOT_W-1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_W-1);
    localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(2*SLOT_W-2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV-1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_next;
    logic             bclk_reg;
    logic             lrclk_reg;
    logic             div_wrap;

    // Strobes fire in the cycle whose closing edge drives bclk low.
    assign div_wrap  = (div_cnt_reg == DIV_LAST);
    assign fall_evt  = div_wrap && bclk_reg;
    assign frame_evt = fall_evt && (bit_cnt_reg == LAST_BIT);

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (frame_evt) begin
            bit_cnt_next = '0;
        end else if (fall_evt) begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            bit_cnt_reg <= LAST_BIT;
            lrclk_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
            if (div_wrap) begin
                bclk_reg <= ~bclk_reg;
            end
            bit_cnt_reg <= bit_cnt_next;
            // Word select leads each slot MSB by one bit.
            lrclk_reg   <= (bit_cnt_next >= WS_FIRST) && (bit_cnt_next <= WS_LAST);
        end
    end

    assign bclk    = bclk_reg;
    assign lrclk   = lrclk_reg;
    assign bit_cnt = bit_cnt_reg;
endmodule

// File: rtl/eq_i2s_tx.sv
// eq_i2s_tx: buffers one stereo frame from a valid/ready stream and serializes it as I2S.
// Build option EQ_I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module eq_i2s_tx
    import eq_pkg::*;
#(
    parameter int DATA_W   = AUDIO_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data_l,
    input  logic [DATA_W-1:0] s_data_r,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata
`ifdef EQ_I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);
    localparam int BIT_W = cnt_w(2*SLOT_W);
    localparam logic [BIT_W-1:0] R_FIRST = BIT_W'(SLOT_W);

    generate
        if (SLOT_W < DATA_W || BCLK_DIV < 1) begin : g_bad_cfg
            $error("eq_i2s_tx: needs SLOT_W >= DATA_W and BCLK_DIV >= 1");
        end
    endgenerate

    logic              fall_evt;
    logic              frame_evt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic              accept;
    logic              hold_valid_reg;
    logic              hold_valid_next;
    logic              s_ready_reg;
    logic              sdata_reg;
    logic [DATA_W-1:0] hold_l_reg;
    logic [DATA_W-1:0] hold_r_reg;
    logic [DATA_W-1:0] sreg_l_reg;
    logic [DATA_W-1:0] sreg_r_reg;
    logic [DATA_W-1:0] load_l;
    logic [DATA_W-1:0] load_r;
    logic [DATA_W-1:0] shl_l;
    logic [DATA_W-1:0] shl_r;

    eq_i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .bclk      (i2s_bclk),
        .lrclk     (i2s_lrclk),
        .fall_evt  (fall_evt),
        .frame_evt (frame_evt),
        .bit_cnt   (bit_cnt)
    );

    assign accept   = s_valid && s_ready_reg;
    // An empty holding register at a frame boundary sends a silent frame.
    assign load_l   = hold_valid_reg ? hold_l_reg : '0;
    assign load_r   = hold_valid_reg ? hold_r_reg : '0;
    assign bit_next = bit_cnt + BIT_W'(1);
    assign shl_l    = sreg_l_reg << 1;
    assign shl_r    = sreg_r_reg << 1;

    always_comb begin
        hold_valid_next = hold_valid_reg;
        if (frame_evt) begin
            hold_valid_next = 1'b0;
        end
        if (accept) begin
            hold_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            s_ready_reg    <= 1'b1;
            hold_l_reg     <= '0;
            hold_r_reg     <= '0;
            sreg_l_reg     <= '0;
            sreg_r_reg     <= '0;
            sdata_reg      <= 1'b0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            s_ready_reg    <= !hold_valid_next;
            if (accept) begin
                hold_l_reg <= s_data_l;
                hold_r_reg <= s_data_r;
            end
            if (frame_evt) begin
                sreg_l_reg <= load_l;
                sreg_r_reg <= load_r;
                sdata_reg  <= load_l[DATA_W-1];
            end else if (fall_evt) begin
                // Zeros shift in behind the sample, padding the slot tail.
                if (bit_next < R_FIRST) begin
                    sreg_l_reg <= shl_l;
                    sdata_reg  <= shl_l[DATA_W-1];
                end else if (bit_next == R_FIRST) begin
                    sdata_reg  <= sreg_r_reg[DATA_W-1];
                end else begin
                    sreg_r_reg <= shl_r;
                    sdata_reg  <= shl_r[DATA_W-1];
                end
            end
        end
    end

    assign s_ready   = s_ready_reg;
    assign i2s_sdata = sdata_reg;

`ifdef EQ_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt_reg <= '0;
        end else if (frame_evt && !hold_valid_reg && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_reg;
`endif
endmodule

// File: tb/tb_eq_i2s_tx.sv
// tb_eq_i2s_tx: cycle-level scoreboard bench for eq_i2s_tx with BCLK_DIV=2, SLOT_W=32.
// Define EQ_I2S_TX_UNDERRUN_CNT_EN to also check underrun_cnt.
`timescale 1ns/1ps
module tb_eq_i2s_tx;
    localparam int DATA_W     = 24;
    localparam int SLOT_W     = 32;
    localparam int BCLK_DIV   = 2;
    localparam int BIT_CLKS   = 2*BCLK_DIV;
    localparam int FRAME_CLKS = 2*SLOT_W*BIT_CLKS;
    localparam int FIRST_BND  = BIT_CLKS-1;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] s_data_l = '0;
    logic [DATA_W-1:0] s_data_r = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
`ifdef EQ_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    eq_i2s_tx #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_l  (s_data_l),
        .s_data_r  (s_data_r),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata)
`ifdef EQ_I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    frame_t hold_q[$];
    frame_t cur_frame    = '0;
    logic   model_full   = 1'b0;
    logic   checking     = 1'b0;
    int     cyc          = 0;
    int     acc_cnt      = 0;
    int     frame_no     = 0;
    int     exp_underrun = 0;
    int     compared     = 0;
    int     mismatched   = 0;

    function automatic int bit_of(input int c);
        if (c < BIT_CLKS) return 2*SLOT_W-1;
        return ((c - BIT_CLKS) / BIT_CLKS) % (2*SLOT_W);
    endfunction

    function automatic logic exp_bclk(input int c);
        return ((c / BCLK_DIV) % 2) == 1;
    endfunction

    function automatic logic exp_lrclk(input int c);
        int b;
        b = bit_of(c);
        return (b >= SLOT_W-1) && (b <= 2*SLOT_W-2);
    endfunction

    function automatic logic exp_sdata(input int c, input frame_t f);
        int b;
        int p;
        logic [DATA_W-1:0] w;
        b = bit_of(c);
        p = b % SLOT_W;
        w = (b < SLOT_W) ? f.l : f.r;
        w = w << p;
        return w[DATA_W-1];
    endfunction

    function automatic logic is_bnd(input int c);
        return (c >= FIRST_BND) && (((c - FIRST_BND) % FRAME_CLKS) == 0);
    endfunction

    // Scoreboard: accepted frames queue up, each frame boundary pops one or goes silent.
    always @(posedge clk) begin
        if (rst) begin
            hold_q.delete();
            model_full   <= 1'b0;
            cur_frame    <= '0;
            cyc          <= 0;
            exp_underrun <= 0;
        end else begin
            if (is_bnd(cyc)) begin
                frame_no <= frame_no + 1;
                if (model_full) begin
                    $display("frame %0d at cycle %0d: L=%h R=%h", frame_no, cyc, hold_q[0].l, hold_q[0].r);
                    cur_frame <= hold_q.pop_front();
                end else begin
                    $display("frame %0d at cycle %0d: underrun, silent", frame_no, cyc);
                    cur_frame    <= '0;
                    exp_underrun <= (exp_underrun < 65535) ? exp_underrun + 1 : exp_underrun;
                end
            end
            if (s_valid && !model_full) begin
                hold_q.push_back(frame_t'({s_data_l, s_data_r}));
                acc_cnt    <= acc_cnt + 1;
                model_full <= 1'b1;
                $display("accept at cycle %0d: L=%h R=%h", cyc, s_data_l, s_data_r);
            end else if (is_bnd(cyc)) begin
                model_full <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            compared++;
            assert (i2s_bclk === exp_bclk(cyc)) else begin
                mismatched++;
                $error("FAIL bclk cyc=%0d got=%b exp=%b", cyc, i2s_bclk, exp_bclk(cyc));
            end
            compared++;
            assert (i2s_lrclk === exp_lrclk(cyc)) else begin
                mismatched++;
                $error("FAIL lrclk cyc=%0d got=%b exp=%b", cyc, i2s_lrclk, exp_lrclk(cyc));
            end
            compared++;
            assert (i2s_sdata === exp_sdata(cyc, cur_frame)) else begin
                mismatched++;
                $error("FAIL sdata cyc=%0d bit=%0d got=%b exp=%b", cyc, bit_of(cyc), i2s_sdata, exp_sdata(cyc, cur_frame));
            end
            compared++;
            assert (s_ready === !model_full) else begin
                mismatched++;
                $error("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, !model_full);
            end
`ifdef EQ_I2S_TX_UNDERRUN_CNT_EN
            compared++;
            assert (underrun_cnt === 16'(exp_underrun)) else begin
                mismatched++;
                $error("FAIL underrun_cnt cyc=%0d got=%0d exp=%0d", cyc, underrun_cnt, exp_underrun);
            end
`endif
        end
    end

    task automatic do_reset();
        s_valid = 1'b0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input logic keep);
        int start;
        start    = acc_cnt;
        s_data_l = l;
        s_data_r = r;
        s_valid  = 1'b1;
        for (int i = 0; i < 4*FRAME_CLKS && acc_cnt == start; i++) begin
            @(posedge clk);
            #1;
        end
        if (acc_cnt == start) begin
            compared++;
            mismatched++;
            $error("FAIL accept_timeout got=none exp=accept of L=%h", l);
        end
        if (!keep) s_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        checking = 1'b1;

        // Reset, idle: silent frames, bclk/lrclk timing from cycle 0.
        wait_clks(600);

        // Single frame presented at cycle 0.
        do_reset();
        send(24'h800001, 24'h7FFFFE, 1'b0);
        wait_clks(600);

        // Backpressure: s_valid stays high across three samples.
        send(24'h123456, 24'hABCDEF, 1'b1);
        send(24'h0F0F0F, 24'hF0F0F0, 1'b1);
        send(24'h5A5A5A, 24'hA5A5A5, 1'b0);
        wait_clks(600);

        // Underrun between two samples.
        send(24'h400000, 24'hC00000, 1'b0);
        wait_clks(3*FRAME_CLKS);
        send(24'h000FFF, 24'hFFF000, 1'b0);
        wait_clks(2*FRAME_CLKS + 10);

        // Sample offered exactly on a frame-boundary cycle with the hold empty.
        for (int i = 0; i < 2*FRAME_CLKS && !is_bnd(cyc); i++) wait_clks(1);
        if (!is_bnd(cyc)) begin
            compared++;
            mismatched++;
            $error("FAIL boundary_wait got=cyc%0d exp=boundary", cyc);
        end
        s_data_l = 24'h3C3C3C;
        s_data_r = 24'hC3C3C3;
        s_valid  = 1'b1;
        wait_clks(1);
        s_valid  = 1'b0;
        wait_clks(600);

        // Reset at bit 40 while a second sample is held.
        send(24'h111111, 24'h222222, 1'b0);
        send(24'h333333, 24'h444444, 1'b0);
        for (int i = 0; i < 2*FRAME_CLKS && bit_of(cyc) != 40; i++) wait_clks(1);
        do_reset();
        wait_clks(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
